spi_reg_if: RTL
===============

// Module: spi_reg_if
// PURPOSE
//  SPI target front-end that turns SPI frames into single-cycle register-bank requests.
//  Sits directly upstream of the register bank inside tt_um_calonso88_spi_i2c_reg_bank.
//  All SPI pins are oversampled in the clk domain; SPI mode 0 only (CPOL=0, CPHA=0), MSB first.
//  Frame: cmd byte {RnW, -, addr[ADDR_W-1:0]} then one data byte (write: MOSI; read: MISO).
// PARAMETERS
//  ADDR_W   3   register address width; cmd bits [ADDR_W-1:0]; bits [6:ADDR_W] ignored
//  DATA_W   8   register data width; fixed at 8 for this frame format
// PORTS
//  clk          in   1       system clock; all state on rising edge
//  rst          in   1       asynchronous, active-high reset
//  spi_cs_n     in   1       chip select, active low, asynchronous to clk
//  spi_sclk     in   1       SPI clock, asynchronous to clk
//  spi_mosi     in   1       controller-to-target data
//  spi_miso     out  1       target-to-controller data
//  spi_miso_oe  out  1       MISO output enable; 1 while synchronized cs_n is low
//  reg_addr     out  ADDR_W  register address; held from cmd byte until next frame
//  reg_wdata    out  DATA_W  write data; valid in the reg_we cycle, held afterwards
//  reg_we       out  1       one-cycle write strobe
//  reg_re       out  1       one-cycle read strobe
//  reg_rdata    in   DATA_W  read data; sampled exactly one cycle after reg_re
//  frame_err    out  1       one-cycle pulse when cs_n rises mid-frame (<16 bits)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; shift regs, bit_cnt and synchronizers cleared.
//  Input sync: cs_n, sclk and mosi each pass a 2-FF synchronizer.
//   cs_n synchronizer resets to 1; others reset to 0.
//  Edge detect: registered copy of synced sclk gives rise/fall pulses (1 clk each).
//  Timing requirement: each SCLK high and low phase must last >= 4 clk cycles (f_clk >= 8*f_sclk).
//  FSM: IDLE -> CMD on synced cs_n low.
//   CMD: on each rise, shift mosi into cmd_sr and increment bit_cnt (0..7).
//    On the 8th rise, latch RnW and addr, clear bit_cnt, go to DATA.
//    If RnW=1, assert reg_re in the next cycle (E+1).
//    In cycle E+2, load reg_rdata into tx_sr; spi_miso = tx_sr[7] immediately.
//   DATA: rise shifts mosi into rx_sr and increments bit_cnt.
//    fall shifts tx_sr left (fill 0), but only when bit_cnt != 0.
//    The byte-boundary fall therefore never drops tx bit 7.
//    On the 8th rise: if write, reg_wdata <= {rx_sr[6:0], mosi} and reg_we = 1 next cycle; go to DONE.
//    If read, go to DONE with no strobe.
//   DONE: extra SCLK edges ignored; spi_miso = 0; no further strobes.
//   Any state: synced cs_n high -> IDLE and bit_cnt = 0 in the same cycle.
//    frame_err pulses if leaving CMD, or DATA before its 8th rise.
//    No reg_we on abort; a reg_re already issued is not retracted.
//  spi_miso drives 0 in IDLE, CMD and DONE.
//  Simultaneous cs_n rise and sclk rise in one cycle: cs_n wins; the edge is discarded.
//  reg_we and reg_re never both 1; at most one strobe per frame.
//  Reset mid-frame: immediate return to reset state, no strobe.
//   The next frame requires a fresh cs_n falling edge after rst deasserts.
// STRUCTURE
//  Package spi_reg_pkg: state enum {IDLE, CMD, DATA, DONE}; RNW_BIT = 7; BYTE_BITS = 8.
//  One sub-module: sync_2ff (1-bit, parameter RST_VAL), instanced 3x for cs_n, sclk, mosi.
//  Rest in one always_ff block plus combinational outputs; no other hierarchy.
// TESTING
//  Write: cmd 0x03, data 0xA5 -> exactly one reg_we, reg_addr=3, reg_wdata=0xA5; reg_re never set.
//  Read: cmd 0x85, reg_rdata=0x3C -> one reg_re with reg_addr=5; MISO byte 2 = 0x3C; no reg_we.
//  Abort: cs_n rises after 12 SCLK bits of a write -> no reg_we; frame_err = 1 for 1 cycle; state IDLE.
//  Extra bytes: write cmd 0x02, data 0x11, then byte 0xFF -> one reg_we (0x11); MISO = 0 in byte 3.
//  Reset mid-frame: rst pulsed after 5 bits -> all outputs 0.
//   Next full write frame (0x07/0x5A) -> reg_we, addr 7, data 0x5A.
//  Min ratio: SCLK phases of exactly 4 clk, back-to-back read of 0x81 (rdata 0xC3) -> MISO 0xC3 bit-exact.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register front-end.
//   state_t   : frame FSM states (IDLE, CMD, DATA, DONE)
//   RNW_BIT   : position of the read/not-write flag in the command byte
//   BYTE_BITS : bits per SPI byte
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } state_t;

  localparam int unsigned RNW_BIT   = 7;
  localparam int unsigned BYTE_BITS = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
//   clk, rst : system clock, asynchronous active-high reset
//   i_d      : asynchronous input
//   o_q      : synchronized output (RST_VAL while in reset)
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/spi_reg_if.sv
// SPI mode-0 target front-end producing single-cycle register-bank requests.
// Frame: command byte {RnW, -, addr} followed by one data byte, MSB first.
//   clk, rst            : system clock, asynchronous active-high reset
//   spi_cs_n/sclk/mosi  : SPI inputs, oversampled in the clk domain
//   spi_miso, _oe       : read data out, enable while synced cs_n is low
//   reg_addr/wdata      : request address and write data (held)
//   reg_we, reg_re      : one-cycle write / read strobes
//   reg_rdata           : read data, sampled one cycle after reg_re
//   frame_err           : one-cycle pulse when a frame is cut short
module spi_reg_if
  import spi_reg_pkg::*;
#(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              frame_err
);

  logic w_cs_n, w_sclk, w_mosi;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst(rst), .i_d(spi_cs_n), .o_q(w_cs_n));
  sync_2ff #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .i_d(spi_sclk), .o_q(w_sclk));
  sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .i_d(spi_mosi), .o_q(w_mosi));

  state_t              r_state, w_state_nxt;
  logic                r_sclk_d;
  logic [2:0]          r_bit_cnt;
  logic [6:0]          r_cmd_sr;
  logic [6:0]          r_rx_sr;
  logic [DATA_W-1:0]   r_tx_sr;
  logic                r_rnw;
  logic                r_load_pend;
  logic [1:0]          r_settle;
  logic                r_armed;
  logic [ADDR_W-1:0]   r_reg_addr;
  logic [DATA_W-1:0]   r_reg_wdata;
  logic                r_reg_we, r_reg_re, r_frame_err;

  logic                w_rise, w_fall, w_last, w_abort;
  logic [BYTE_BITS-1:0] w_cmd_byte, w_rx_byte;

  assign w_rise     = w_sclk & ~r_sclk_d;
  assign w_fall     = ~w_sclk & r_sclk_d;
  assign w_last     = (r_bit_cnt == 3'(BYTE_BITS - 1));
  assign w_cmd_byte = {r_cmd_sr, w_mosi};
  assign w_rx_byte  = {r_rx_sr, w_mosi};

  // cs_n high always wins, so a coincident sclk rise is simply dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_abort     = 1'b0;
    if (w_cs_n) begin
      w_state_nxt = IDLE;
      w_abort     = (r_state == CMD) || (r_state == DATA);
    end else begin
      case (r_state)
        IDLE:    if (r_armed) w_state_nxt = CMD;
        CMD:     if (w_rise && w_last) w_state_nxt = DATA;
        DATA:    if (w_rise && w_last) w_state_nxt = DONE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sclk_d    <= 1'b0;
      r_bit_cnt   <= '0;
      r_cmd_sr    <= '0;
      r_rx_sr     <= '0;
      r_tx_sr     <= '0;
      r_rnw       <= 1'b0;
      r_load_pend <= 1'b0;
      r_settle    <= '0;
      r_armed     <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_reg_we    <= 1'b0;
      r_reg_re    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sclk_d    <= w_sclk;
      r_reg_we    <= 1'b0;
      r_reg_re    <= 1'b0;
      r_frame_err <= w_abort;
      r_load_pend <= r_reg_re;
      // The cs_n synchronizer shows its reset value for a few cycles; only
      // a cs_n high seen after that arms the FSM, so a frame already in
      // progress at reset release is ignored until cs_n goes high again.
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
      else if (w_cs_n)      r_armed  <= 1'b1;
      if (r_load_pend) r_tx_sr <= reg_rdata;

      if (w_cs_n) begin
        r_bit_cnt <= '0;
      end else begin
        case (r_state)
          CMD: if (w_rise) begin
            r_cmd_sr  <= w_cmd_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_last) begin
              r_rnw      <= w_cmd_byte[RNW_BIT];
              r_reg_addr <= w_cmd_byte[ADDR_W-1:0];
              r_reg_re   <= w_cmd_byte[RNW_BIT];
            end
          end
          DATA: if (w_rise) begin
            r_rx_sr   <= w_rx_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_last && !r_rnw) begin
              r_reg_wdata <= w_rx_byte;
              r_reg_we    <= 1'b1;
            end
          end else if (w_fall && r_bit_cnt != 3'd0) begin
            // The fall right after the command byte leaves bit 7 in place.
            r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
          end
          default: ;
        endcase
      end
    end
  end

  assign spi_miso    = (r_state == DATA) ? r_tx_sr[DATA_W-1] : 1'b0;
  assign spi_miso_oe = ~w_cs_n;
  assign reg_addr    = r_reg_addr;
  assign reg_wdata   = r_reg_wdata;
  assign reg_we      = r_reg_we;
  assign reg_re      = r_reg_re;
  assign frame_err   = r_frame_err;

endmodule
